// File: rtl/register_write_arbiter.sv
// Round-robin write arbiter for one shared holding register: picks a requester,
// replays its data through a LOAD/ACK sequence, and services clear requests.
module register_write_arbiter #(
    parameter int WIDTH     = 8,
    parameter int N_REQ     = 4,
    parameter int CNT_WIDTH = 16,
    localparam int OW       = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic                   clr,
    output logic [N_REQ-1:0]       ack,
    output logic                   reg_load,
    output logic [WIDTH-1:0]       reg_data,
    output logic                   reg_clear,
    output logic                   busy,
    output logic [OW-1:0]          owner,
    output logic [CNT_WIDTH-1:0]   wr_count,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ACK   = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [OW-1:0]        rr_q, rr_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic                 load_q, clear_q, busy_q;

    logic [WIDTH-1:0]     req_word [N_REQ];
    logic                 found;
    logic [OW-1:0]        win;
    logic [OW-1:0]        cand;
    int                   scan_idx;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_word[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Rotating priority scan: first set request at or after rr_q, wrapping.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        cand     = '0;
        scan_idx = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = (int'(rr_q) + i) % N_REQ;
            cand     = OW'(scan_idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                end else if (found) begin
                    data_d  = req_word[win];
                    owner_d = win;
                    state_d = LOAD;
                end
            end
            LOAD:  state_d = ACK;
            ACK: begin
                rr_d    = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + OW'(1);
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                state_d = IDLE;
            end
            CLEAR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they are flopped yet line up with it.
        if (state_d == ACK) begin
            ack_d[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            load_q  <= 1'b0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            load_q  <= (state_d == LOAD);
            clear_q <= (state_d == CLEAR);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign ack       = ack_q;
    assign reg_load  = load_q;
    assign reg_data  = data_q;
    assign reg_clear = clear_q;
    assign busy      = busy_q;
    assign owner     = owner_q;
    assign wr_count  = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Bench for register_write_arbiter: directed scenarios plus random traffic, all
// outputs compared each cycle against a transaction-schedule reference model.
module tb_register_write_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic           clr;
    logic [N-1:0]   ack;
    logic           reg_load;
    logic [W-1:0]   reg_data;
    logic           reg_clear;
    logic           busy;
    logic [1:0]     owner;
    logic [CW-1:0]  wr_count;
    logic [1:0]     dbg_state;

    register_write_arbiter #(.WIDTH(W), .N_REQ(N), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .clr       (clr),
        .ack       (ack),
        .reg_load  (reg_load),
        .reg_data  (reg_data),
        .reg_clear (reg_clear),
        .busy      (busy),
        .owner     (owner),
        .wr_count  (wr_count),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a decision at edge e schedules the outputs of the next cycles.
    int           m_cyc = 0;
    int           m_next_dec;
    int           m_cnt_edge;
    int           m_rr;
    int           m_owner;
    int           m_cnt;
    logic [W-1:0] m_data;
    logic         s_load  [4];
    logic         s_clear [4];
    logic [N-1:0] s_ack   [4];

    logic [W-1:0] obs_q[$];
    logic [N-1:0] ack_q[$];
    int           evt_q[$];

    task automatic model_reset();
        m_rr       = 0;
        m_owner    = 0;
        m_cnt      = 0;
        m_data     = '0;
        m_cnt_edge = -1;
        m_next_dec = m_cyc + 1;
        for (int i = 0; i < 4; i++) begin
            s_load[i]  = 1'b0;
            s_clear[i] = 1'b0;
            s_ack[i]   = '0;
        end
    endtask

    task automatic model_edge();
        int  win;
        bit  hit;
        m_cyc++;
        if (!rst) begin
            model_reset();
            return;
        end
        if (m_cyc == m_cnt_edge) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            m_rr  = (m_owner + 1) % N;
        end
        if (m_cyc == m_next_dec) begin
            if (clr) begin
                s_clear[m_cyc % 4] = 1'b1;
                m_next_dec = m_cyc + 2;
            end else if (req != '0) begin
                hit = 0;
                win = 0;
                for (int i = 0; i < N; i++) begin
                    if (!hit && req[(m_rr + i) % N]) begin
                        hit = 1;
                        win = (m_rr + i) % N;
                    end
                end
                m_owner = win;
                m_data  = req_data[win*W +: W];
                s_load[m_cyc % 4] = 1'b1;
                s_ack[(m_cyc + 1) % 4] = N'(1) << win;
                m_cnt_edge = m_cyc + 2;
                m_next_dec = m_cyc + 3;
            end else begin
                m_next_dec = m_cyc + 1;
            end
        end
    endtask

    task automatic check_outputs();
        int s;
        s = m_cyc % 4;
        check_val("ack",       32'(ack),       32'(s_ack[s]));
        check_val("reg_load",  32'(reg_load),  32'(s_load[s]));
        check_val("reg_clear", 32'(reg_clear), 32'(s_clear[s]));
        check_val("busy",      32'(busy),      32'(s_load[s] | s_clear[s] | (s_ack[s] != '0)));
        check_val("owner",     32'(owner),     32'(m_owner));
        check_val("wr_count",  32'(wr_count),  32'(m_cnt));
        check_val("reg_data",  32'(reg_data),  32'(m_data));
        if (reg_load)  begin obs_q.push_back(reg_data); evt_q.push_back(1); end
        if (ack != '0) begin ack_q.push_back(ack);      evt_q.push_back(2); end
        if (reg_clear) evt_q.push_back(3);
        s_load[s]  = 1'b0;
        s_clear[s] = 1'b0;
        s_ack[s]   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle_steps(input int n);
        req = '0;
        clr = 1'b0;
        repeat (n) step();
    endtask

    task automatic clear_logs();
        obs_q.delete();
        ack_q.delete();
        evt_q.delete();
    endtask

    int cnt0;

    initial begin
        rst      = 1'b0;
        req      = '0;
        req_data = '0;
        clr      = 1'b0;
        model_reset();
        #2;
        check_outputs();
        repeat (2) step();
        rst = 1'b1;

        // Single write from requester 2.
        clear_logs();
        req = 4'b0100;
        req_data = {8'h00, 8'h55, 8'h00, 8'h00};
        step();
        req = '0;
        repeat (3) step();
        check_val("single_data",  32'(obs_q.size() > 0 ? obs_q[0] : 8'h00), 32'h55);
        check_val("single_ack",   32'(ack_q.size() > 0 ? ack_q[0] : 4'h0), 32'b0100);
        check_val("single_count", 32'(wr_count), 32'd1);
        check_val("single_owner", 32'(owner), 32'd2);
        idle_steps(2);

        // Round-robin with all four requesting; pointer starts at 3 after the write above.
        // Reset the pointer first so the grant order begins at requester 0.
        rst = 1'b0;
        model_reset();
        #1;
        rst = 1'b1;
        idle_steps(1);
        clear_logs();
        req = 4'b1111;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        repeat (15) step();
        req = '0;
        repeat (3) step();
        check_val("rr_count", 32'(obs_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            logic [W-1:0] exp_d;
            exp_d = 8'h11 * W'((i % 4) + 1);
            check_val("rr_data", 32'(i < obs_q.size() ? obs_q[i] : 8'h00), 32'(exp_d));
        end

        // Pointer wrap: requester 3 wins, then 1001 grants 0 before 3.
        idle_steps(1);
        clear_logs();
        req = 4'b1000;
        step();
        req = '0;
        repeat (2) step();
        req = 4'b1001;
        repeat (6) step();
        req = '0;
        repeat (3) step();
        check_val("wrap_n", 32'(ack_q.size()), 32'd3);
        check_val("wrap_1", 32'(ack_q.size() > 1 ? ack_q[1] : 4'h0), 32'b0001);
        check_val("wrap_2", 32'(ack_q.size() > 2 ? ack_q[2] : 4'h0), 32'b1000);

        // Clear beats a simultaneous request.
        idle_steps(1);
        clear_logs();
        cnt0 = int'(wr_count);
        clr = 1'b1;
        req = 4'b0001;
        req_data = {8'h00, 8'h00, 8'h00, 8'hAA};
        step();
        clr = 1'b0;
        repeat (2) step();
        req = '0;
        repeat (3) step();
        check_val("clrpri_first", 32'(evt_q.size() > 0 ? evt_q[0] : 0), 32'd3);
        check_val("clrpri_data",  32'(obs_q.size() > 0 ? obs_q[0] : 8'h00), 32'hAA);
        check_val("clrpri_count", 32'(wr_count), 32'((cnt0 + 1) % (1 << CW)));

        // Clear raised during LOAD waits for the write to finish.
        idle_steps(1);
        clear_logs();
        req = 4'b0010;
        req_data = {8'h00, 8'h00, 8'h5A, 8'h00};
        step();
        req = '0;
        clr = 1'b1;
        repeat (3) step();
        clr = 1'b0;
        repeat (2) step();
        check_val("clrmid_n",  32'(evt_q.size()), 32'd3);
        check_val("clrmid_e0", 32'(evt_q.size() > 0 ? evt_q[0] : 0), 32'd1);
        check_val("clrmid_e1", 32'(evt_q.size() > 1 ? evt_q[1] : 0), 32'd2);
        check_val("clrmid_e2", 32'(evt_q.size() > 2 ? evt_q[2] : 0), 32'd3);

        // Asynchronous reset during LOAD aborts the write.
        idle_steps(1);
        clear_logs();
        req = 4'b0100;
        req_data = {8'h00, 8'h77, 8'h00, 8'h00};
        step();
        check_val("arst_loading", 32'(reg_load), 32'd1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        req = '0;
        repeat (2) step();
        rst = 1'b1;
        req = 4'b0010;
        req_data = {8'h00, 8'h00, 8'h66, 8'h00};
        step();
        req = '0;
        repeat (3) step();
        check_val("arst_acks",  32'(ack_q.size()), 32'd1);
        check_val("arst_ack",   32'(ack_q.size() > 0 ? ack_q[0] : 4'h0), 32'b0010);
        check_val("arst_owner", 32'(owner), 32'd1);
        check_val("arst_count", 32'(wr_count), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req      = N'($urandom_range(0, 15));
            req_data = {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
            clr      = ($urandom_range(0, 9) == 0);
            step();
        end
        idle_steps(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
